// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared widths, lane record and constants for register writeback
package reg_writeback_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int NUM_REGS  = 32;
    localparam int NUM_LANES = 3;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One execution-lane result as seen by the write stage
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } lane_t;

endpackage

// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - issue/result inputs and reg_file write port bundle
interface reg_writeback_if;
    import reg_writeback_pkg::*;

    logic                flush;
    logic                iss_valid1, iss_valid2, iss_valid3;
    logic [ADDR_W-1:0]   iss_rd1, iss_rd2, iss_rd3;
    logic                ex_valid1, ex_valid2, ex_valid3;
    logic [ADDR_W-1:0]   ex_rd1, ex_rd2, ex_rd3;
    logic [DATA_W-1:0]   ex_data1, ex_data2, ex_data3;
    logic                RegWr1, RegWr2, RegWr3;
    logic [ADDR_W-1:0]   Rw1, Rw2, Rw3;
    logic [DATA_W-1:0]   busW1, busW2, busW3;
    logic [NUM_REGS-1:0] busy;
    logic                waw_err;

    // Upstream pipeline: drives issue/result lanes, observes write ports
    modport master (
        output flush, iss_valid1, iss_valid2, iss_valid3, iss_rd1, iss_rd2, iss_rd3,
               ex_valid1, ex_valid2, ex_valid3, ex_rd1, ex_rd2, ex_rd3,
               ex_data1, ex_data2, ex_data3,
        input  RegWr1, RegWr2, RegWr3, Rw1, Rw2, Rw3, busW1, busW2, busW3,
               busy, waw_err
    );

    // Writeback stage: consumes lanes, drives reg_file ports and scoreboard
    modport slave (
        input  flush, iss_valid1, iss_valid2, iss_valid3, iss_rd1, iss_rd2, iss_rd3,
               ex_valid1, ex_valid2, ex_valid3, ex_rd1, ex_rd2, ex_rd3,
               ex_data1, ex_data2, ex_data3,
        output RegWr1, RegWr2, RegWr3, Rw1, Rw2, Rw3, busW1, busW2, busW3,
               busy, waw_err
    );

endinterface

// File: rtl/reg_writeback_wb_scoreboard.sv
// rtl/reg_writeback_wb_scoreboard.sv - pending-write mask with flush and WAW protocol checking
module wb_scoreboard
    import reg_writeback_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic [NUM_LANES-1:0]                iss_valid_i,
    input  logic [NUM_LANES-1:0][ADDR_W-1:0]    iss_rd_i,
    input  logic [NUM_LANES-1:0]                ex_valid_i,
    input  logic [NUM_LANES-1:0][ADDR_W-1:0]    ex_rd_i,
    output logic [NUM_REGS-1:0]                 busy_o,
    output logic                                waw_err_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_vec, clr_vec;
    logic                err_q, err_d;
    // After a flush, results for squashed-upstream issues may still arrive;
    // do not flag them until a fresh issue re-establishes the mask.
    logic                supp_q, supp_d;
    logic                issue_seen;

    // Next busy mask, suppression window and error detection
    always_comb begin
        set_vec    = '0;
        clr_vec    = '0;
        issue_seen = 1'b0;
        err_d      = err_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (ex_valid_i[k] && ex_rd_i[k] != REG_ZERO) begin
                clr_vec[ex_rd_i[k]] = 1'b1;
            end
            if (iss_valid_i[k] && iss_rd_i[k] != REG_ZERO) begin
                set_vec[iss_rd_i[k]] = 1'b1;
                issue_seen           = 1'b1;
            end
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!flush_i && iss_valid_i[k] && iss_rd_i[k] != REG_ZERO) begin
                if (busy_q[iss_rd_i[k]] && !clr_vec[iss_rd_i[k]]) begin
                    err_d = 1'b1;
                end
                for (int j = 0; j < k; j++) begin
                    if (iss_valid_i[j] && iss_rd_i[j] == iss_rd_i[k]) begin
                        err_d = 1'b1;
                    end
                end
            end
            if (ex_valid_i[k] && ex_rd_i[k] != REG_ZERO && !busy_q[ex_rd_i[k]] && !supp_q) begin
                err_d = 1'b1;
            end
        end
        if (flush_i) begin
            busy_d = '0;
            supp_d = 1'b1;
        end else begin
            busy_d = (busy_q & ~clr_vec) | set_vec;
            supp_d = issue_seen ? 1'b0 : supp_q;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
            supp_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            supp_q <= supp_d;
        end
    end

    assign busy_o    = busy_q;
    assign waw_err_o = err_q;

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - three-lane result writeback with youngest-wins conflict resolution
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    reg_writeback_if.slave  bus
);

    lane_t                             ex [NUM_LANES];
    logic [NUM_LANES-1:0]              regwr_q, regwr_d;
    logic [NUM_LANES-1:0][ADDR_W-1:0]  rw_q, rw_d;
    logic [NUM_LANES-1:0][DATA_W-1:0]  busw_q, busw_d;
    logic [NUM_LANES-1:0]              iss_valid, ex_valid;
    logic [NUM_LANES-1:0][ADDR_W-1:0]  iss_rd, ex_rd;

    assign ex[0] = '{valid: bus.ex_valid1, rd: bus.ex_rd1, data: bus.ex_data1};
    assign ex[1] = '{valid: bus.ex_valid2, rd: bus.ex_rd2, data: bus.ex_data2};
    assign ex[2] = '{valid: bus.ex_valid3, rd: bus.ex_rd3, data: bus.ex_data3};

    assign iss_valid = {bus.iss_valid3, bus.iss_valid2, bus.iss_valid1};
    assign iss_rd    = {bus.iss_rd3, bus.iss_rd2, bus.iss_rd1};
    assign ex_valid  = {bus.ex_valid3, bus.ex_valid2, bus.ex_valid1};
    assign ex_rd     = {bus.ex_rd3, bus.ex_rd2, bus.ex_rd1};

    // Per-lane write enable: drop r0 and any lane shadowed by a younger same-rd lane
    always_comb begin
        regwr_d = '0;
        rw_d    = rw_q;
        busw_d  = busw_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (ex[k].valid) begin
                rw_d[k]    = ex[k].rd;
                busw_d[k]  = ex[k].data;
                regwr_d[k] = (ex[k].rd != REG_ZERO);
                for (int j = k + 1; j < NUM_LANES; j++) begin
                    if (ex[j].valid && ex[j].rd == ex[k].rd) begin
                        regwr_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Registered reg_file write ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwr_q <= '0;
            rw_q    <= '0;
            busw_q  <= '0;
        end else begin
            regwr_q <= regwr_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (bus.flush),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .ex_valid_i  (ex_valid),
        .ex_rd_i     (ex_rd),
        .busy_o      (bus.busy),
        .waw_err_o   (bus.waw_err)
    );

    assign bus.RegWr1 = regwr_q[0];
    assign bus.RegWr2 = regwr_q[1];
    assign bus.RegWr3 = regwr_q[2];
    assign bus.Rw1    = rw_q[0];
    assign bus.Rw2    = rw_q[1];
    assign bus.Rw3    = rw_q[2];
    assign bus.busW1  = busw_q[0];
    assign bus.busW2  = busw_q[1];
    assign bus.busW3  = busw_q[2];

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed self-checking bench for reg_writeback
module tb_reg_writeback;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    logic [31:0] rf [32];

    reg_writeback_if bus ();

    reg_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model fed by the write ports, port 3 written last
    always @(posedge clk) begin
        if (bus.RegWr1) rf[bus.Rw1] <= bus.busW1;
        if (bus.RegWr2) rf[bus.Rw2] <= bus.busW2;
        if (bus.RegWr3) rf[bus.Rw3] <= bus.busW3;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        bus.flush      = 1'b0;
        bus.iss_valid1 = 1'b0; bus.iss_valid2 = 1'b0; bus.iss_valid3 = 1'b0;
        bus.iss_rd1    = '0;   bus.iss_rd2    = '0;   bus.iss_rd3    = '0;
        bus.ex_valid1  = 1'b0; bus.ex_valid2  = 1'b0; bus.ex_valid3  = 1'b0;
        bus.ex_rd1     = '0;   bus.ex_rd2     = '0;   bus.ex_rd3     = '0;
        bus.ex_data1   = '0;   bus.ex_data2   = '0;   bus.ex_data3   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        clr_in();
        rst_n = 1'b0;
        step();
        step();
        check("rst_regwr", {29'd0, bus.RegWr3, bus.RegWr2, bus.RegWr1}, 32'd0);
        check("rst_rw1", {27'd0, bus.Rw1}, 32'd0);
        check("rst_busw3", bus.busW3, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_err", {31'd0, bus.waw_err}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of an active write
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd5;
        step();
        check("iss5_busy", bus.busy, 32'h0000_0020);
        clr_in();
        bus.ex_valid1 = 1'b1; bus.ex_rd1 = 5'd5; bus.ex_data1 = 32'hAA;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 32'd0);
        check("midrst_regwr1", {31'd0, bus.RegWr1}, 32'd0);
        step();
        clr_in();
        rst_n = 1'b1;
        step();
        check("postrst_regwr1", {31'd0, bus.RegWr1}, 32'd0);
        check("postrst_rw1", {27'd0, bus.Rw1}, 32'd0);
        check("postrst_busw1", bus.busW1, 32'd0);

        // Three independent lanes
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd17;
        bus.iss_valid2 = 1'b1; bus.iss_rd2 = 5'd21;
        bus.iss_valid3 = 1'b1; bus.iss_rd3 = 5'd3;
        step();
        check("iss3_busy", bus.busy, 32'h0022_0008);
        clr_in();
        bus.ex_valid1 = 1'b1; bus.ex_rd1 = 5'd17; bus.ex_data1 = 32'd255;
        bus.ex_valid2 = 1'b1; bus.ex_rd2 = 5'd21; bus.ex_data2 = 32'd189;
        bus.ex_valid3 = 1'b1; bus.ex_rd3 = 5'd3;  bus.ex_data3 = 32'd56;
        step();
        check("lanes_regwr", {29'd0, bus.RegWr3, bus.RegWr2, bus.RegWr1}, 32'd7);
        check("lanes_rw", {17'd0, bus.Rw1, bus.Rw2, bus.Rw3}, {17'd0, 5'd17, 5'd21, 5'd3});
        check("lanes_busw1", bus.busW1, 32'd255);
        check("lanes_busw2", bus.busW2, 32'd189);
        check("lanes_busw3", bus.busW3, 32'd56);
        check("lanes_busy", bus.busy, 32'd0);
        check("lanes_err", {31'd0, bus.waw_err}, 32'd0);
        clr_in();
        step();
        check("idle_regwr", {29'd0, bus.RegWr3, bus.RegWr2, bus.RegWr1}, 32'd0);
        check("idle_rw1_hold", {27'd0, bus.Rw1}, 32'd17);
        check("idle_busw2_hold", bus.busW2, 32'd189);
        check("rf17", rf[17], 32'd255);
        check("rf21", rf[21], 32'd189);
        check("rf3", rf[3], 32'd56);

        // Same-cycle WAW: youngest lane wins
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd29;
        step();
        clr_in();
        bus.ex_valid1 = 1'b1; bus.ex_rd1 = 5'd29; bus.ex_data1 = 32'd10;
        bus.ex_valid2 = 1'b1; bus.ex_rd2 = 5'd29; bus.ex_data2 = 32'd20;
        bus.ex_valid3 = 1'b1; bus.ex_rd3 = 5'd29; bus.ex_data3 = 32'd120;
        step();
        check("waw_regwr", {29'd0, bus.RegWr3, bus.RegWr2, bus.RegWr1}, 32'd4);
        check("waw_rw3", {27'd0, bus.Rw3}, 32'd29);
        check("waw_busw3", bus.busW3, 32'd120);
        check("waw_err_clear", {31'd0, bus.waw_err}, 32'd0);
        clr_in();
        step();
        check("rf29", rf[29], 32'd120);

        // r0 is never written nor tracked
        bus.ex_valid2 = 1'b1; bus.ex_rd2 = 5'd0; bus.ex_data2 = 32'hFFFF;
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd0;
        step();
        check("r0_regwr2", {31'd0, bus.RegWr2}, 32'd0);
        check("r0_busy", bus.busy, 32'd0);
        check("r0_err", {31'd0, bus.waw_err}, 32'd0);
        clr_in();

        // Scoreboard set / same-cycle clear+set / illegal re-issue
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd14;
        step();
        check("sb_set14", bus.busy, 32'h0000_4000);
        clr_in();
        bus.ex_valid1 = 1'b1; bus.ex_rd1 = 5'd14; bus.ex_data1 = 32'd7;
        bus.iss_valid2 = 1'b1; bus.iss_rd2 = 5'd14;
        step();
        check("sb_setwins", bus.busy, 32'h0000_4000);
        check("sb_noerr", {31'd0, bus.waw_err}, 32'd0);
        clr_in();
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd14;
        step();
        check("sb_reissue_err", {31'd0, bus.waw_err}, 32'd1);
        clr_in();
        step();
        check("sb_err_sticky", {31'd0, bus.waw_err}, 32'd1);

        // Two lanes issuing the same register
        do_reset();
        bus.iss_valid2 = 1'b1; bus.iss_rd2 = 5'd8;
        bus.iss_valid3 = 1'b1; bus.iss_rd3 = 5'd8;
        step();
        check("dupiss_busy", bus.busy, 32'h0000_0100);
        check("dupiss_err", {31'd0, bus.waw_err}, 32'd1);

        // Flush clears busy, commits in-flight result, suppresses stale errors
        do_reset();
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd1;
        bus.iss_valid2 = 1'b1; bus.iss_rd2 = 5'd3;
        bus.iss_valid3 = 1'b1; bus.iss_rd3 = 5'd14;
        step();
        check("fl_busy_pre", bus.busy, 32'h0000_400A);
        clr_in();
        bus.flush = 1'b1;
        bus.ex_valid1 = 1'b1; bus.ex_rd1 = 5'd1; bus.ex_data1 = 32'h1234;
        bus.iss_valid2 = 1'b1; bus.iss_rd2 = 5'd9;
        step();
        check("fl_busy", bus.busy, 32'd0);
        check("fl_regwr1", {31'd0, bus.RegWr1}, 32'd1);
        check("fl_busw1", bus.busW1, 32'h1234);
        clr_in();
        bus.ex_valid2 = 1'b1; bus.ex_rd2 = 5'd3; bus.ex_data2 = 32'h55;
        step();
        check("fl_late_noerr", {31'd0, bus.waw_err}, 32'd0);
        check("fl_late_regwr2", {31'd0, bus.RegWr2}, 32'd1);
        clr_in();
        bus.iss_valid1 = 1'b1; bus.iss_rd1 = 5'd7;
        bus.ex_valid3 = 1'b1; bus.ex_rd3 = 5'd9; bus.ex_data3 = 32'h66;
        step();
        check("fl_supp_until_iss", {31'd0, bus.waw_err}, 32'd0);
        check("fl_busy7", bus.busy, 32'h0000_0080);
        clr_in();
        bus.ex_valid1 = 1'b1; bus.ex_rd1 = 5'd9; bus.ex_data1 = 32'h77;
        step();
        check("nonbusy_ex_err", {31'd0, bus.waw_err}, 32'd1);
        clr_in();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Initiator side of the 3-port register-file write interface in the superscalar MIPS core.
- Collects results from three execution lanes, with lane 1 oldest and lane 3 youngest.
- Registers the results, resolves same-cycle destination conflicts and suppresses writes to r0.
- Drives RegWr/Rw/busW for reg_file ports 1-3 and keeps a per-register pending-write scoreboard that issue logic uses for RAW/WAW stalls.

Parameters:
- DATA_W, 32, width of result data and busW.
- ADDR_W, 5, register index width (2**ADDR_W registers).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; clears the scoreboard.
- iss_valid1/2/3  in  1  lane k issues an instruction that will write a register.
- iss_rd1/2/3  in  ADDR_W  destination of the issuing instruction on lane k.
- ex_valid1/2/3  in  1  lane k result is valid this cycle.
- ex_rd1/2/3  in  ADDR_W  destination register of the lane k result.
- ex_data1/2/3  in  DATA_W  result value of lane k.
- RegWr1/2/3  out  1  write enable to reg_file port k.
- Rw1/2/3  out  ADDR_W  write address to reg_file port k.
- busW1/2/3  out  DATA_W  write data to reg_file port k.
- busy  out  2**ADDR_W  pending-write mask; bit r=1 means register r has an issued, uncommitted write.
- waw_err  out  1  sticky error flag for protocol violations.

Behaviour:
- Reset (async, rst_n=0): RegWr*=0, Rw*=0, busW*=0, busy=0, waw_err=0. Reset mid-operation discards captured results; nothing is committed.
- Write stage, latency 1:
  - At posedge, lane k captures Rw_k=ex_rd_k and busW_k=ex_data_k.
  - RegWr_k is registered as: ex_valid_k AND ex_rd_k!=0 AND no younger lane j>k with ex_valid_j and ex_rd_j==ex_rd_k.
  - Same-cycle WAW is resolved by the youngest lane winning; older duplicates are dropped.
  - Outputs hold for exactly one cycle. With no valid input, RegWr*=0 next cycle; Rw/busW hold their previous values.
- Scoreboard:
  - Set: iss_valid_k with iss_rd_k!=0 sets busy[iss_rd_k] at posedge.
  - Clear: ex_valid_k with ex_rd_k!=0 clears busy[ex_rd_k] at posedge, in the same cycle the result is captured.
  - Set and clear of the same register in the same cycle: set wins, because a new write was issued.
  - busy[0] is constant 0.
- flush:
  - Clears all busy bits at posedge; same-cycle issues are also ignored.
  - Results already captured, or arriving with flush, still commit. The write path is not squashed here; squashing is upstream's job.
- waw_err is set, and stays set until reset, when any of these occurs:
  - iss_valid_k targets a register already busy with no same-cycle clear;
  - two lanes issue to the same non-zero rd in one cycle;
  - ex_valid_k targets a non-busy non-zero register, unless flush occurred in an earlier cycle (suppression holds until the next issue).
- Arithmetic: none. All comparisons are ADDR_W-bit equality.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W and NUM_REGS=32;
  - NUM_LANES=3 and REG_ZERO=0;
  - a lane-record typedef {valid, rd, data}.
- Sub-module wb_scoreboard holds the busy mask with set/clear/flush logic and WAW error detection.
- reg_writeback instantiates wb_scoreboard and contains the conflict-resolution and output registers.

Test Plan:
- Reset during active writes (ex_valid1=1, rd=5, data=0xAA; rst_n low mid-cycle) -> RegWr*=0 and busy=0 immediately; no commit after rst_n rises.
- Single lanes: lane1 rd=17 data=255, lane2 rd=21 data=189, lane3 rd=3 data=56 in one cycle -> next cycle RegWr1/2/3=1, Rw=17/21/3, busW=255/189/56; reg_file readback matches.
- Same-cycle WAW: all lanes rd=29 with data 10/20/120 -> only RegWr3=1, Rw3=29, busW3=120; reg_file r29=120.
- r0 suppression: lane2 ex_rd=0 data=0xFFFF -> RegWr2=0; issue to rd=0 leaves busy[0]=0.
- Scoreboard: issue rd=14 on lane1 -> busy[14]=1 next cycle; ex lane1 rd=14 while lane2 issues rd=14 same cycle -> busy[14] stays 1, waw_err=0; re-issue rd=14 while busy without clear -> waw_err=1.
- Flush: busy={1,3,14}, flush with same-cycle ex lane1 rd=1 -> busy=0, RegWr1=1 next cycle; a later ex to rd=3 does not set waw_err.
